mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences the single shared memory port between the fetch stage (instruction reads) and the memory stage (data loads and stores) of the five-stage pipeline. The port has variable latency with a busy/done handshake. The block:
- grants the port,
- tracks the one outstanding access,
- discards fetch responses killed by a redirect flush,
- produces the freeze signals the pipeline combines with the decode-stage load-use stall.

## Interface
Parameters
- ADDR_W, 16, address width
- DATA_W, 16, data width
- CNT_W, 16, width of the saturating stall-cycle counter

Ports
- clk  in  1  clock; everything is on the rising edge
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch wants an instruction at if_addr
- if_addr  in  ADDR_W  fetch address
- if_valid  out  1  one-cycle pulse; if_rdata is valid
- if_rdata  out  DATA_W  instruction word
- mem_req  in  1  memory stage has a load or store
- mem_wr  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_done  out  1  one-cycle pulse; access complete, mem_rdata valid for loads
- mem_rdata  out  DATA_W  load data
- flush  in  1  redirect from decode; kills the in-flight fetch
- stall_if  out  1  freeze PC and IF/ID
- stall_mem  out  1  freeze the whole pipeline
- m_en  out  1  issue strobe to memory
- m_wr  out  1  write enable to memory
- m_addr  out  ADDR_W  address to memory
- m_wdata  out  DATA_W  write data to memory
- m_busy  in  1  memory cannot accept an issue this cycle
- m_done  in  1  response or write-ack; m_rdata valid
- m_rdata  in  DATA_W  read data from memory
- err  out  1  sticky protocol/alignment error
- stall_cnt  out  CNT_W  saturating count of cycles with stall_if or stall_mem high

## Operation
- States: IDLE, IF_WAIT, MEM_WAIT, IF_DROP.
- IDLE, granting the memory stage (priority):
  - Condition: mem_req=1, mem_addr[0]=0, m_busy=0.
  - Action: m_en=1, m_wr=mem_wr, m_addr=mem_addr, m_wdata=mem_wdata; go to MEM_WAIT.
- IDLE, granting fetch:
  - Condition: mem_req=0, if_req=1, if_addr[0]=0, m_busy=0, flush=0.
  - Action: m_en=1, m_wr=0, m_addr=if_addr; go to IF_WAIT.
- IDLE, no grant: when m_busy=1, nothing is issued and the state stays IDLE.
- Misaligned requests (address bit 0 set): never issued; err is set; the requester stays stalled until reset.
- MEM_WAIT: on m_done, pulse mem_done, drive mem_rdata=m_rdata (combinational pass-through), go to IDLE. flush is ignored in this state.
- IF_WAIT:
  - On m_done with flush=0: pulse if_valid with if_rdata=m_rdata, go to IDLE.
  - On m_done with flush=1: no if_valid, go to IDLE.
  - On flush without m_done: go to IF_DROP.
- IF_DROP: on m_done, discard the response, no pulses, go to IDLE.
- mem_req arriving during IF_WAIT or IF_DROP waits for that access to finish, then wins in IDLE.
- Stall outputs:
  - stall_mem = mem_req & ~mem_done.
  - stall_if = stall_mem | (if_req & ~if_valid).
- m_en, m_wr, m_addr, m_wdata are 0 whenever no issue occurs.
- err is set by m_done in IDLE or by a misaligned request, and holds until reset.
- stall_cnt increments each cycle stall_if|stall_mem=1 and saturates at all-ones.
- Reset (any state, including mid-access): state goes to IDLE; err and stall_cnt clear. The memory shares rst_n, so no stale m_done follows.

## Timing
- Reset values: all outputs 0, state IDLE.
- Issue occurs in cycle T. The earliest m_done is T+1, so zero-wait latency is 2 cycles from request to done pulse.
- No issue occurs in the same cycle as a done. The next issue is the cycle after the done, at the earliest.
- Issue-to-issue minimum is 2 cycles. At most one access is outstanding.
- if_valid and mem_done are never high in the same cycle. Each is high for exactly one cycle per completed access.
- mem_req and if_req held stable by the pipeline while stalled; the block does not latch addresses.

## Test plan
- Zero-wait load: mem_req=1, mem_wr=0, mem_addr=0x0010, m_done at T+1 with m_rdata=0xBEEF -> m_en at T, mem_done and mem_rdata=0xBEEF at T+1, stall_mem high at T only.
- Contention: if_req and mem_req both asserted in IDLE -> MEM issued first; after its m_done, IF issued on the following cycle; if_valid follows 1 cycle after that with zero-wait memory.
- Flush during fetch with 3-cycle latency:
  - if_addr=0x0100 issued at T, flush at T+1 -> IF_DROP.
  - m_done at T+3 -> no if_valid.
  - New fetch issued at T+4.
- m_busy backpressure: m_busy=1 for 4 cycles while mem_req=1 -> no m_en and stall_cnt +4; issue occurs on the first cycle with m_busy=0.
- Errors:
  - mem_addr=0x0011 -> err=1 and no m_en.
  - Spurious m_done in IDLE -> err=1.
  - Both are cleared only by rst_n=0.
- Reset in MEM_WAIT: rst_n=0 for 1 cycle -> state IDLE, all outputs 0, stall_cnt=0; a fresh load completes normally afterwards.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one variable-latency memory port between the fetch stage (reads)
// and the memory stage (loads/stores). Only one access is outstanding at a
// time. The memory stage wins when both ask in the same cycle. A fetch
// response that a redirect flush has killed is dropped. The block also
// generates the pipeline freeze signals and a saturating stall counter.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   if_req/if_addr     fetch request and address
//   if_valid/if_rdata  one-cycle fetch completion and instruction word
//   mem_req/mem_wr     memory-stage request, 1 = store
//   mem_addr/mem_wdata memory-stage address and store data
//   mem_done/mem_rdata one-cycle memory-stage completion and load data
//   flush              redirect; kills the in-flight fetch
//   stall_if           freeze PC and IF/ID
//   stall_mem          freeze the whole pipeline
//   m_en/m_wr          issue strobe and write enable to memory
//   m_addr/m_wdata     address and write data to memory
//   m_busy             memory cannot accept an issue this cycle
//   m_done/m_rdata     memory response / write-ack and read data
//   err                sticky protocol or alignment error
//   stall_cnt          saturating count of stalled cycles

module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              mem_req,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_done,
   output logic [DATA_W-1:0] mem_rdata,
   input  logic              flush,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              m_en,
   output logic              m_wr,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_busy,
   input  logic              m_done,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              err,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_IF_WAIT,
      S_MEM_WAIT,
      S_IF_DROP
   } state_t;

   state_t            r_state;
   logic              r_err;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_idle;
   logic w_mem_grant;
   logic w_if_grant;
   logic w_mem_misalign;
   logic w_if_misalign;
   logic w_spurious_done;
   logic w_mem_done;
   logic w_if_valid;
   logic w_stall_any;

   // Grant and completion decode. The port handshake is combinational:
   // an issue appears in the same cycle as the request, and a completion
   // pulse appears in the same cycle as m_done. Nothing issues while reset
   // is asserted.
   always_comb begin
      w_idle          = (r_state == S_IDLE);
      w_mem_grant     = rst_n & w_idle & mem_req & ~mem_addr[0] & ~m_busy;
      w_if_grant      = rst_n & w_idle & ~mem_req & if_req & ~if_addr[0]
                        & ~m_busy & ~flush;
      w_mem_misalign  = w_idle & mem_req & mem_addr[0];
      w_if_misalign   = w_idle & ~mem_req & if_req & if_addr[0];
      w_spurious_done = w_idle & m_done;
      w_mem_done      = rst_n & (r_state == S_MEM_WAIT) & m_done;
      // A flush arriving with the response itself still kills it.
      w_if_valid      = rst_n & (r_state == S_IF_WAIT) & m_done & ~flush;
   end

   // Memory-side outputs are zero whenever nothing is issued.
   always_comb begin
      m_en    = w_mem_grant | w_if_grant;
      m_wr    = w_mem_grant & mem_wr;
      m_addr  = '0;
      m_wdata = '0;
      if (w_mem_grant) begin
         m_addr  = mem_addr;
         m_wdata = mem_wdata;
      end else if (w_if_grant) begin
         m_addr  = if_addr;
      end
   end

   // Pipeline-side outputs.
   always_comb begin
      mem_done  = w_mem_done;
      mem_rdata = w_mem_done ? m_rdata : '0;
      if_valid  = w_if_valid;
      if_rdata  = w_if_valid ? m_rdata : '0;
      stall_mem = mem_req & ~w_mem_done;
      stall_if  = (mem_req & ~w_mem_done) | (if_req & ~w_if_valid);
      w_stall_any = stall_if | stall_mem;
   end

   // Access-tracking state machine.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_mem_grant) begin
                  r_state <= S_MEM_WAIT;
               end else if (w_if_grant) begin
                  r_state <= S_IF_WAIT;
               end
            end
            S_IF_WAIT: begin
               if (m_done) begin
                  r_state <= S_IDLE;
               end else if (flush) begin
                  r_state <= S_IF_DROP;
               end
            end
            S_MEM_WAIT: begin
               if (m_done) begin
                  r_state <= S_IDLE;
               end
            end
            S_IF_DROP: begin
               if (m_done) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Sticky error: a misaligned request or a response with nothing
   // outstanding. Only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_mem_misalign | w_if_misalign | w_spurious_done) begin
         r_err <= 1'b1;
      end
   end

   // Saturating stall-cycle counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_stall_any && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign err       = r_err;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 8;

   logic          clk;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_valid;
   logic [DW-1:0] if_rdata;
   logic          mem_req;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_done;
   logic [DW-1:0] mem_rdata;
   logic          flush;
   logic          stall_if;
   logic          stall_mem;
   logic          m_en;
   logic          m_wr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_busy;
   logic          m_done;
   logic [DW-1:0] m_rdata;
   logic          err;
   logic [CW-1:0] stall_cnt;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata), .flush(flush),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_busy(m_busy), .m_done(m_done), .m_rdata(m_rdata),
      .err(err), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          rst, ifr;
      logic [AW-1:0] ifa;
      logic          mr, mw;
      logic [AW-1:0] ma;
      logic [DW-1:0] mwd;
      logic          fl, bz, dn;
      logic [DW-1:0] rd;
      logic          e_en, e_wr;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      logic          e_iv;
      logic [DW-1:0] e_ird;
      logic          e_md;
      logic [DW-1:0] e_mrd;
      logic          e_sif, e_smem, e_err;
   } vec_t;

   typedef struct {
      logic          fetch;
      logic [DW-1:0] data;
   } exp_t;

   vec_t tbl[$];
   exp_t sbq[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t v(
      input logic rst, ifr, input logic [AW-1:0] ifa,
      input logic mr, mw, input logic [AW-1:0] ma, input logic [DW-1:0] mwd,
      input logic fl, bz, dn, input logic [DW-1:0] rd,
      input logic e_en, e_wr, input logic [AW-1:0] e_addr, input logic [DW-1:0] e_wd,
      input logic e_iv, input logic [DW-1:0] e_ird,
      input logic e_md, input logic [DW-1:0] e_mrd,
      input logic e_sif, e_smem, e_err);
      vec_t r;
      r.rst = rst; r.ifr = ifr; r.ifa = ifa; r.mr = mr; r.mw = mw; r.ma = ma;
      r.mwd = mwd; r.fl = fl; r.bz = bz; r.dn = dn; r.rd = rd;
      r.e_en = e_en; r.e_wr = e_wr; r.e_addr = e_addr; r.e_wd = e_wd;
      r.e_iv = e_iv; r.e_ird = e_ird; r.e_md = e_md; r.e_mrd = e_mrd;
      r.e_sif = e_sif; r.e_smem = e_smem; r.e_err = e_err;
      return r;
   endfunction

   // Idle-input vector with only err expected.
   function automatic vec_t vz(input logic rst, input logic e_err);
      return v(rst,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,e_err);
   endfunction

   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      return {a[7:0], a[15:8]} ^ 16'hA5C3;
   endfunction

   task automatic drive_idle(input logic rst);
      rst_n = rst; if_req = 0; if_addr = '0; mem_req = 0; mem_wr = 0;
      mem_addr = '0; mem_wdata = '0; flush = 0; m_busy = 0; m_done = 0; m_rdata = '0;
   endtask

   logic [78:0]   act, expv;
   logic [CW-1:0] e_cnt;

   initial begin
      drive_idle(1'b0);
      repeat (2) @(posedge clk);

      // in: rst ifr ifa mr mw ma mwd fl bz dn rd | out: en wr addr wd iv ird md mrd sif smem err
      tbl.push_back(vz(1,0));
      // zero-wait load and store
      tbl.push_back(v(1,0,0,1,0,'h10,0,0,0,0,0,        1,0,'h10,0,0,0,0,0,1,1,0));
      tbl.push_back(v(1,0,0,1,0,'h10,0,0,0,1,'hBEEF,   0,0,0,0,0,0,1,'hBEEF,0,0,0));
      tbl.push_back(vz(1,0));
      tbl.push_back(v(1,0,0,1,1,'h20,'h1234,0,0,0,0,   1,1,'h20,'h1234,0,0,0,0,1,1,0));
      tbl.push_back(v(1,0,0,1,1,'h20,'h1234,0,0,1,0,   0,0,0,0,0,0,1,0,0,0,0));
      // contention: memory first, then fetch
      tbl.push_back(v(1,1,'h40,1,0,'h30,0,0,0,0,0,      1,0,'h30,0,0,0,0,0,1,1,0));
      tbl.push_back(v(1,1,'h40,1,0,'h30,0,0,0,1,'h5555, 0,0,0,0,0,0,1,'h5555,1,0,0));
      tbl.push_back(v(1,1,'h40,0,0,0,0,0,0,0,0,         1,0,'h40,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h40,0,0,0,0,0,0,1,'h1111,    0,0,0,0,1,'h1111,0,0,0,0,0));
      tbl.push_back(vz(1,0));
      // flush during 3-cycle fetch
      tbl.push_back(v(1,1,'h100,0,0,0,0,0,0,0,0,        1,0,'h100,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h100,0,0,0,0,1,0,0,0,        0,0,0,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h200,0,0,0,0,0,0,0,0,        0,0,0,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h200,0,0,0,0,0,0,1,'hDEAD,   0,0,0,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h200,0,0,0,0,0,0,0,0,        1,0,'h200,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h200,0,0,0,0,0,0,1,'h2222,   0,0,0,0,1,'h2222,0,0,0,0,0));
      // flush with the response, then flush in IDLE blocks the fetch
      tbl.push_back(v(1,1,'h300,0,0,0,0,0,0,0,0,        1,0,'h300,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h300,0,0,0,0,1,0,1,'h3333,   0,0,0,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h300,0,0,0,0,1,0,0,0,        0,0,0,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h304,0,0,0,0,0,0,0,0,        1,0,'h304,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h304,0,0,0,0,0,0,1,'h4444,   0,0,0,0,1,'h4444,0,0,0,0,0));
      // flush ignored in MEM_WAIT
      tbl.push_back(v(1,0,0,1,0,'h50,0,0,0,0,0,         1,0,'h50,0,0,0,0,0,1,1,0));
      tbl.push_back(v(1,0,0,1,0,'h50,0,1,0,0,0,         0,0,0,0,0,0,0,0,1,1,0));
      tbl.push_back(v(1,0,0,1,0,'h50,0,0,0,1,'h6666,    0,0,0,0,0,0,1,'h6666,0,0,0));
      // mem_req arrives during IF_WAIT
      tbl.push_back(v(1,1,'h400,0,0,0,0,0,0,0,0,        1,0,'h400,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h400,1,0,'h60,0,0,0,0,0,     0,0,0,0,0,0,0,0,1,1,0));
      tbl.push_back(v(1,1,'h400,1,0,'h60,0,0,0,1,'h7777,0,0,0,0,1,'h7777,0,0,1,1,0));
      tbl.push_back(v(1,1,'h402,1,0,'h60,0,0,0,0,0,     1,0,'h60,0,0,0,0,0,1,1,0));
      tbl.push_back(v(1,1,'h402,1,0,'h60,0,0,0,1,'h8888,0,0,0,0,0,0,1,'h8888,1,0,0));
      tbl.push_back(v(1,1,'h402,0,0,0,0,0,0,0,0,        1,0,'h402,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h402,0,0,0,0,0,0,1,'h9999,   0,0,0,0,1,'h9999,0,0,0,0,0));
      // backpressure: 4 busy cycles
      for (int i = 0; i < 4; i++)
         tbl.push_back(v(1,0,0,1,0,'h70,0,0,1,0,0,      0,0,0,0,0,0,0,0,1,1,0));
      tbl.push_back(v(1,0,0,1,0,'h70,0,0,0,0,0,         1,0,'h70,0,0,0,0,0,1,1,0));
      tbl.push_back(v(1,0,0,1,0,'h70,0,0,0,1,'hAAAA,    0,0,0,0,0,0,1,'hAAAA,0,0,0));
      tbl.push_back(v(1,1,'h500,0,0,0,0,0,1,0,0,        0,0,0,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h500,0,0,0,0,0,0,0,0,        1,0,'h500,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h500,0,0,0,0,0,0,1,'hBBBB,   0,0,0,0,1,'hBBBB,0,0,0,0,0));
      // misaligned load -> sticky err
      tbl.push_back(v(1,0,0,1,0,'h11,0,0,0,0,0,         0,0,0,0,0,0,0,0,1,1,0));
      tbl.push_back(vz(1,1));
      tbl.push_back(vz(0,1));
      tbl.push_back(vz(1,0));
      // spurious m_done in IDLE
      tbl.push_back(v(1,0,0,0,0,0,0,0,0,1,'hCCCC,       0,0,0,0,0,0,0,0,0,0,0));
      tbl.push_back(vz(1,1));
      tbl.push_back(vz(0,1));
      tbl.push_back(vz(1,0));
      // misaligned fetch
      tbl.push_back(v(1,1,'h101,0,0,0,0,0,0,0,0,        0,0,0,0,0,0,0,0,1,0,0));
      tbl.push_back(v(1,1,'h101,0,0,0,0,0,0,0,0,        0,0,0,0,0,0,0,0,1,0,1));
      tbl.push_back(vz(1,1));
      tbl.push_back(vz(0,1));
      tbl.push_back(vz(1,0));
      // reset in MEM_WAIT, then a fresh load
      tbl.push_back(v(1,0,0,1,0,'h80,0,0,0,0,0,         1,0,'h80,0,0,0,0,0,1,1,0));
      tbl.push_back(vz(0,0));
      tbl.push_back(vz(1,0));
      tbl.push_back(v(1,0,0,1,0,'h82,0,0,0,0,0,         1,0,'h82,0,0,0,0,0,1,1,0));
      tbl.push_back(v(1,0,0,1,0,'h82,0,0,0,1,'hDDDD,    0,0,0,0,0,0,1,'hDDDD,0,0,0));
      tbl.push_back(vz(1,0));

      e_cnt = '0;
      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk); #1;
         rst_n = tbl[i].rst; if_req = tbl[i].ifr; if_addr = tbl[i].ifa;
         mem_req = tbl[i].mr; mem_wr = tbl[i].mw; mem_addr = tbl[i].ma;
         mem_wdata = tbl[i].mwd; flush = tbl[i].fl; m_busy = tbl[i].bz;
         m_done = tbl[i].dn; m_rdata = tbl[i].rd;
         #3;
         act  = {m_en, m_wr, m_addr, m_wdata, if_valid, if_rdata, mem_done, mem_rdata,
                 stall_if, stall_mem, err, stall_cnt};
         expv = {tbl[i].e_en, tbl[i].e_wr, tbl[i].e_addr, tbl[i].e_wd, tbl[i].e_iv,
                 tbl[i].e_ird, tbl[i].e_md, tbl[i].e_mrd, tbl[i].e_sif, tbl[i].e_smem,
                 tbl[i].e_err, e_cnt};
         n_vec++;
         if (act !== expv) begin
            n_err++;
            $display("FAIL vec%0d {en,wr,addr,wd,iv,ird,md,mrd,sif,smem,err,cnt}: got %h want %h",
                     i, act, expv);
         end
         if (!tbl[i].rst) e_cnt = '0;
         else if ((tbl[i].e_sif || tbl[i].e_smem) && e_cnt != '1) e_cnt = e_cnt + 1'b1;
      end

      // Scoreboard run against a responder with random latency and busy.
      begin
         logic          pend, is_f, done, got_f;
         int            lat, budget;
         logic [AW-1:0] raddr, a;
         logic [DW-1:0] got_d;
         exp_t          e;
         pend = 0; lat = 0; raddr = '0;
         for (int t = 0; t < 24; t++) begin
            is_f = 1'($urandom_range(0, 1));
            a    = 16'($urandom) & 16'hFFFE;
            sbq.push_back('{is_f, memf(a)});
            done = 0; budget = 0;
            while (!done) begin
               @(posedge clk); #1;
               rst_n = 1; flush = 0; mem_wr = 0; mem_wdata = '0;
               if_req = is_f; if_addr = is_f ? a : '0;
               mem_req = !is_f; mem_addr = is_f ? '0 : a;
               m_done = pend && (lat == 0);
               m_rdata = m_done ? memf(raddr) : '0;
               m_busy = ($urandom_range(0, 3) == 0);
               #3;
               if (if_valid || mem_done) begin
                  n_vec++;
                  got_f = if_valid;
                  got_d = if_valid ? if_rdata : mem_rdata;
                  if (sbq.size() == 0) begin
                     n_err++;
                     $display("FAIL sb%0d unexpected completion fetch=%0b data=%h", t, got_f, got_d);
                  end else begin
                     e = sbq.pop_front();
                     if (got_f !== e.fetch || got_d !== e.data) begin
                        n_err++;
                        $display("FAIL sb%0d completion: got fetch=%0b data=%h want fetch=%0b data=%h",
                                 t, got_f, got_d, e.fetch, e.data);
                     end
                  end
                  done = 1;
               end
               if (m_done) pend = 0;
               else if (pend && lat != 0) lat--;
               if (m_en) begin
                  pend = 1; lat = $urandom_range(0, 2); raddr = m_addr;
               end
               budget++;
               if (!done && budget > 40) begin
                  n_vec++; n_err++;
                  $display("FAIL sb%0d timeout: no completion within 40 cycles, want 1", t);
                  sbq.delete();
                  done = 1;
               end
            end
         end
      end

      // Counter saturation: a misaligned load stalls indefinitely.
      @(posedge clk); #1; drive_idle(1'b0);
      @(posedge clk); #1; drive_idle(1'b1); mem_req = 1; mem_addr = 16'h0011;
      repeat (300) @(posedge clk);
      #4;
      n_vec++;
      if ({stall_cnt, err, m_en, stall_mem} !== {8'hFF, 1'b1, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL saturate {cnt,err,en,smem}: got %h want %h",
                  {stall_cnt, err, m_en, stall_mem}, {8'hFF, 1'b1, 1'b0, 1'b1});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
